way_packed_writer: RTL and testbench
====================================

// Module: way_packed_writer
// PURPOSE
//  Write-side counterpart of the one-hot decoded way mux. Accepts one write per cycle (valid/ready).
//  Scatters the element into one way of a flattened NUMBER_WAYS x element register array.
//  The way is either the one given by a one-hot select or one chosen by allocation.
//  Holds per-way valid bits, a round-robin victim pointer and a flush sequencer.
//  Its way_packed_out/sel outputs feed the decoded mux on the read side.
// PARAMETERS
//  NUMBER_WAYS                  8  ways held; power of two, >= 2
//  SINGLE_ELEMENT_SIZE_IN_BITS  4  bits per way element
// PORTS
//  clk_in            in   1      clock; all state updates on rising edge
//  reset_in          in   1      synchronous, active-high reset
//  write_valid_in    in   1      write request
//  write_ready_out   out  1      block can accept write this cycle
//  write_sel_in      in   NW     one-hot target way; all-zero = allocate
//  write_data_in     in   SEB    element to store
//  invalidate_in     in   NW     per-way valid clear mask (any bit pattern)
//  flush_in          in   1      start a flush of all valid bits
//  way_packed_out    out  SEB*NW way g in bits [(g+1)*SEB-1 : g*SEB]
//  way_valid_out     out  NW     per-way valid bits
//  written_way_out   out  NW     one-hot way written last cycle
//  write_done_out    out  1      1-cycle pulse, write committed
//  flush_busy_out    out  1      flush in progress
// BEHAVIOUR
//  Reset (reset_in=1 at edge): way_packed_out=0, way_valid_out=0, written_way_out=0, write_done_out=0,
//   flush_busy_out=0, victim pointer=0, state=IDLE; reset overrides every other input incl. mid-flush.
//  write_ready_out = (state==IDLE) & ~flush_in (combinational); handshake = write_valid_in & write_ready_out.
//  Way choice on handshake (combinational, same cycle):
//   - write_sel_in != 0: highest set bit wins (same priority as the read mux), multi-hot tolerated.
//   - write_sel_in == 0 and some way invalid: highest-index invalid way.
//   - write_sel_in == 0 and all valid: way[victim pointer]; pointer then +1, wraps NW-1 -> 0.
//   - pointer advances ONLY on that all-valid allocation case.
//  Commit at the next edge (latency 1): element stored, valid bit set, written_way_out=chosen one-hot,
//   write_done_out=1. Without a handshake, written_way_out=0 and write_done_out=0.
//  invalidate_in clears valid bits at the edge (data untouched). Same way written and invalidated
//   in one cycle: write wins, valid=1. Invalidate is honoured in any state.
//  FSM: IDLE --flush_in--> FLUSH; FLUSH clears one valid bit per cycle, index 0..NW-1 (log2(NW)-bit counter).
//   After clearing NW-1 -> IDLE; flush takes exactly NW cycles.
//   flush_busy_out=1 throughout FLUSH; write_ready_out=0 during FLUSH and in the flush_in cycle.
//   flush_in while in FLUSH: ignored (no restart). Victim pointer reset to 0 on FLUSH exit.
//  Write data is never cleared except by reset; only valid bits are flushed.
// TESTING
//  1 Reset, then 8 writes sel=0 with data 0x1..0x8 -> fill ways 7..0 in order;
//    way_packed_out=0x12345678, valid=0xFF.
//  2 Full array, 3 writes sel=0 with data 0xA,0xB,0xC -> ways 0,1,2 replaced; pointer=3;
//    written_way_out 0x01,0x02,0x04.
//  3 Write sel=0x24, data 0x9 -> way 5 written only; write_done_out pulses 1 cycle after handshake.
//  4 Same cycle: write sel=0x08 + invalidate_in=0x0C -> way3 valid=1, way2 valid=0.
//  5 flush_in with valid=0xFF -> ready=0 for 9 cycles (flush_in cycle + 8 FLUSH cycles);
//    valid bits clear 0..7 one per cycle; valid=0x00, pointer=0, busy=0 afterwards.
//  6 reset_in asserted in flush cycle 3 -> next cycle all outputs at reset values, ready=1.

Source files
------------

// File: rtl/way_packed_writer.sv
// Write-side way array: scatters one element per accepted write into a flattened
// NUMBER_WAYS x element register array, with per-way valid bits, round-robin victim and flush.
module way_packed_writer #(
  parameter int unsigned NUMBER_WAYS                 = 8,
  parameter int unsigned SINGLE_ELEMENT_SIZE_IN_BITS = 4
) (
  input  logic                                                clk_in,
  input  logic                                                reset_in,
  input  logic                                                write_valid_in,
  output logic                                                write_ready_out,
  input  logic [NUMBER_WAYS-1:0]                              write_sel_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]              write_data_in,
  input  logic [NUMBER_WAYS-1:0]                              invalidate_in,
  input  logic                                                flush_in,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS*NUMBER_WAYS-1:0]  way_packed_out,
  output logic [NUMBER_WAYS-1:0]                              way_valid_out,
  output logic [NUMBER_WAYS-1:0]                              written_way_out,
  output logic                                                write_done_out,
  output logic                                                flush_busy_out
);

  localparam int unsigned NW  = NUMBER_WAYS;
  localparam int unsigned SEB = SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int unsigned PW  = $clog2(NUMBER_WAYS);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_state_next;
  logic [PW-1:0]   r_flush_cnt;
  logic [PW-1:0]   w_flush_cnt_next;
  logic            w_flush_last;
  logic [PW-1:0]   r_victim;
  logic [NW-1:0]   r_valid;
  logic [SEB*NW-1:0] r_data;

  logic            w_handshake;
  logic [PW-1:0]   w_sel_idx;
  logic [PW-1:0]   w_inv_idx;
  logic [PW-1:0]   w_way_idx;
  logic            w_alloc_victim;
  logic [NW-1:0]   w_write_mask;
  logic [NW-1:0]   w_flush_clr;
  logic [NW-1:0]   w_valid_next;

  assign write_ready_out = (r_state == S_IDLE) && !flush_in;
  assign w_handshake     = write_valid_in && write_ready_out;
  assign flush_busy_out  = (r_state == S_FLUSH);
  assign way_packed_out  = r_data;
  assign way_valid_out   = r_valid;

  // Way choice: explicit select (highest bit), else highest invalid way, else victim.
  always_comb begin
    w_sel_idx      = '0;
    w_inv_idx      = '0;
    w_way_idx      = r_victim;
    w_alloc_victim = 1'b0;
    for (int g = 0; g < int'(NW); g++) begin
      if (write_sel_in[g]) w_sel_idx = PW'(g);
      if (!r_valid[g])     w_inv_idx = PW'(g);
    end
    if (|write_sel_in) begin
      w_way_idx = w_sel_idx;
    end else if (!(&r_valid)) begin
      w_way_idx = w_inv_idx;
    end else begin
      w_alloc_victim = 1'b1;
    end
    w_write_mask = w_handshake ? (NW'(1) << w_way_idx) : '0;
  end

  // Flush sequencer: next state and counter.
  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    w_flush_last     = 1'b0;
    w_flush_clr      = '0;
    case (r_state)
      S_IDLE: begin
        if (flush_in) begin
          w_state_next     = S_FLUSH;
          w_flush_cnt_next = '0;
        end
      end
      S_FLUSH: begin
        w_flush_clr      = NW'(1) << r_flush_cnt;
        w_flush_cnt_next = r_flush_cnt + PW'(1);
        if (r_flush_cnt == PW'(NW - 1)) begin
          w_flush_last = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // A same-cycle write overrides invalidate and flush clears on its way.
  assign w_valid_next = (r_valid & ~invalidate_in & ~w_flush_clr) | w_write_mask;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= '0;
      r_victim    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
      if (w_flush_last) begin
        r_victim <= '0;
      end else if (w_handshake && w_alloc_victim) begin
        r_victim <= r_victim + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_data          <= '0;
      r_valid         <= '0;
      written_way_out <= '0;
      write_done_out  <= 1'b0;
    end else begin
      for (int g = 0; g < int'(NW); g++) begin
        if (w_write_mask[g]) r_data[g*SEB +: SEB] <= write_data_in;
      end
      r_valid         <= w_valid_next;
      written_way_out <= w_write_mask;
      write_done_out  <= w_handshake;
    end
  end

endmodule

// File: tb/tb_way_packed_writer.sv
// Scoreboard bench for way_packed_writer: a behavioural model predicts each committed
// write, flush progression and reset behaviour.
module tb_way_packed_writer;

  localparam int NW  = 8;
  localparam int SEB = 4;

  logic              clk_in = 1'b0;
  logic              reset_in;
  logic              write_valid_in;
  logic              write_ready_out;
  logic [NW-1:0]     write_sel_in;
  logic [SEB-1:0]    write_data_in;
  logic [NW-1:0]     invalidate_in;
  logic              flush_in;
  logic [SEB*NW-1:0] way_packed_out;
  logic [NW-1:0]     way_valid_out;
  logic [NW-1:0]     written_way_out;
  logic              write_done_out;
  logic              flush_busy_out;

  always #5 clk_in = ~clk_in;

  way_packed_writer #(.NUMBER_WAYS(NW), .SINGLE_ELEMENT_SIZE_IN_BITS(SEB)) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .write_valid_in  (write_valid_in),
    .write_ready_out (write_ready_out),
    .write_sel_in    (write_sel_in),
    .write_data_in   (write_data_in),
    .invalidate_in   (invalidate_in),
    .flush_in        (flush_in),
    .way_packed_out  (way_packed_out),
    .way_valid_out   (way_valid_out),
    .written_way_out (written_way_out),
    .write_done_out  (write_done_out),
    .flush_busy_out  (flush_busy_out)
  );

  typedef struct {
    logic [NW-1:0]     way;
    logic [SEB*NW-1:0] pk;
    logic [NW-1:0]     valid;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_writes = 0;
  int   n_done   = 0;

  logic [SEB-1:0] m_data [NW];
  logic [NW-1:0]  m_valid;
  logic [2:0]     m_victim;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [SEB*NW-1:0] m_packed();
    logic [SEB*NW-1:0] p;
    for (int i = 0; i < NW; i++) p[i*SEB +: SEB] = m_data[i];
    return p;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NW; i++) m_data[i] = '0;
    m_valid  = '0;
    m_victim = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_packed"}, way_packed_out, '0);
    chk({tag, "_valid"}, way_valid_out, '0);
    chk({tag, "_written"}, written_way_out, '0);
    chk({tag, "_done"}, write_done_out, 0);
    chk({tag, "_busy"}, flush_busy_out, 0);
    chk({tag, "_ready"}, write_ready_out, 1);
  endtask

  // Output monitor: each done pulse must match the oldest predicted commit.
  always @(negedge clk_in) begin : mon
    exp_t e;
    if (write_done_out) begin
      n_done++;
      chk("sb_nonempty", 64'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("written_way", written_way_out, e.way);
        chk("commit_packed", way_packed_out, e.pk);
        chk("commit_valid", way_valid_out, e.valid);
      end
    end else begin
      chk("written_way_idle", written_way_out, '0);
    end
  end

  task automatic write_op(input logic [NW-1:0] sel, input logic [SEB-1:0] data,
                          input logic [NW-1:0] inv);
    int   w;
    exp_t e;
    @(posedge clk_in); #2;
    write_valid_in = 1'b1;
    write_sel_in   = sel;
    write_data_in  = data;
    invalidate_in  = inv;
    #1 chk("ready_write", write_ready_out, 1);
    w = 0;
    if (sel != '0) begin
      for (int i = 0; i < NW; i++) if (sel[i]) w = i;
    end else if (m_valid != '1) begin
      for (int i = 0; i < NW; i++) if (!m_valid[i]) w = i;
    end else begin
      w = int'(m_victim);
      m_victim = m_victim + 3'd1;
    end
    m_data[w] = data;
    m_valid   = (m_valid & ~inv) | (NW'(1) << w);
    e.way   = NW'(1) << w;
    e.pk    = m_packed();
    e.valid = m_valid;
    sb_q.push_back(e);
    n_writes++;
    @(posedge clk_in); #2;
    write_valid_in = 1'b0;
    write_sel_in   = '0;
    invalidate_in  = '0;
  endtask

  task automatic flush_op(input bit do_reset);
    @(posedge clk_in); #2;
    flush_in = 1'b1;
    #1 chk("ready_flush_in", write_ready_out, 0);
    @(posedge clk_in); #2;
    flush_in = 1'b0;
    for (int i = 0; i < NW; i++) begin
      chk("flush_busy", flush_busy_out, 1);
      chk("flush_ready", write_ready_out, 0);
      chk("flush_valid", way_valid_out, m_valid);
      if (i == 4) flush_in = 1'b1;
      if (do_reset && i == 2) reset_in = 1'b1;
      @(posedge clk_in); #2;
      flush_in = 1'b0;
      if (do_reset && i == 2) begin
        reset_in = 1'b0;
        m_reset();
        chk_reset_outputs("midflush_reset");
        return;
      end
      m_valid[i] = 1'b0;
    end
    m_victim = '0;
    chk("post_flush_busy", flush_busy_out, 0);
    chk("post_flush_ready", write_ready_out, 1);
    chk("post_flush_valid", way_valid_out, m_valid);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_in       = 1'b1;
    write_valid_in = 1'b0;
    write_sel_in   = '0;
    write_data_in  = '0;
    invalidate_in  = '0;
    flush_in       = 1'b0;
    m_reset();
    repeat (2) @(posedge clk_in);
    #2 reset_in = 1'b0;
    #1 chk_reset_outputs("reset");

    // Fill from way 7 downwards.
    for (int i = 1; i <= NW; i++) write_op('0, SEB'(i), '0);
    chk("fill_packed", way_packed_out, 32'h12345678);
    chk("fill_valid", way_valid_out, 8'hFF);

    // Round-robin replacement on a full array.
    write_op('0, 4'hA, '0);
    write_op('0, 4'hB, '0);
    write_op('0, 4'hC, '0);
    chk("victim_packed", way_packed_out, 32'h12345CBA);

    // Multi-hot select: highest bit wins.
    write_op(8'h24, 4'h9, '0);
    chk("sel_packed", way_packed_out, 32'h12945CBA);

    // Write beats invalidate on the same way.
    write_op(8'h08, 4'hD, 8'h0C);
    chk("inv_valid", way_valid_out, 8'hFB);
    chk("inv_packed", way_packed_out, 32'h1294DCBA);

    // Refill the hole, then victim pointer must sit at 3.
    write_op('0, 4'hE, '0);
    write_op('0, 4'h7, '0);
    chk("ptr3_packed", way_packed_out, 32'h12947EBA);

    // Full flush; pointer must return to 0.
    flush_op(1'b0);
    for (int i = 1; i <= NW; i++) write_op('0, SEB'(i), '0);
    write_op('0, 4'hF, '0);
    chk("ptr0_packed", way_packed_out, 32'h1234567F);

    // Reset during flush.
    flush_op(1'b1);

    write_op('0, 4'h5, '0);
    chk("post_reset_packed", way_packed_out, 32'h50000000);

    repeat (3) @(posedge clk_in);
    #2;
    chk("sb_drained", 64'(sb_q.size()), 0);
    chk("done_count", 64'(n_done), 64'(n_writes));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
